// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared widths and state encoding for the register dump controller
package reg_dump_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int REG_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2,
        CSUM   = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump_outreg.sv
// rtl/reg_dump_outreg.sv - output holding register with load and handshake-clear
import reg_dump_pkg::*;

module reg_dump_outreg (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [REG_DATA_W-1:0] load_data,
    input  logic [REG_IDX_W-1:0]  load_idx,
    input  logic                  load_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [REG_DATA_W-1:0] out_data,
    output logic [REG_IDX_W-1:0]  out_idx,
    output logic                  out_last
);

    // Load wins over the handshake clear so a back-to-back word keeps valid high;
    // payload stays frozen until the next load.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_idx   <= load_idx;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - register file scanner/streamer; optional checksum word via REG_DUMP_CSUM_EN
import reg_dump_pkg::*;

module reg_dump_ctrl #(
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31,
    parameter int SETTLE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic [REG_IDX_W-1:0]  reg_sel,
    input  logic [REG_DATA_W-1:0] reg_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_DATA_W-1:0] out_data,
    output logic [REG_IDX_W-1:0]  out_idx,
    output logic                  out_last,
    output logic                  busy
);

    localparam logic [REG_IDX_W-1:0] FIRST_SEL   = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_SEL    = REG_IDX_W'(LAST_REG);
    localparam logic [CNT_W-1:0]     SETTLE_INIT = CNT_W'(SETTLE_CYC);

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic                    hs;
    logic                    load;
    logic [REG_DATA_W-1:0]   load_data;
    logic [REG_IDX_W-1:0]    load_idx;
    logic                    load_last;
    logic                    sel_init;
    logic                    sel_inc;
    logic                    cnt_load;
    logic                    cnt_dec;
    logic                    capture;
`ifdef REG_DUMP_CSUM_EN
    logic [REG_DATA_W-1:0]   csum;
`endif

    assign hs   = out_valid && out_ready;
    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_data  = reg_data;
        load_idx   = reg_sel;
        load_last  = 1'b0;
        sel_init   = 1'b0;
        sel_inc    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sel_init   = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    capture    = 1'b1;
                    load       = 1'b1;
`ifndef REG_DUMP_CSUM_EN
                    load_last  = (reg_sel == LAST_SEL);
`endif
                    state_next = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    if (reg_sel != LAST_SEL) begin
                        sel_inc    = 1'b1;
                        cnt_load   = 1'b1;
                        state_next = SETTLE;
                    end else begin
`ifdef REG_DUMP_CSUM_EN
                        // Checksum word is loaded on the accept edge so it is
                        // presented on the very next cycle.
                        load       = 1'b1;
                        load_data  = csum;
                        load_idx   = LAST_SEL;
                        load_last  = 1'b1;
                        state_next = CSUM;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end
`ifdef REG_DUMP_CSUM_EN
            CSUM: begin
                if (hs) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Register select and settle counter; reg_sel only moves on start or handshake
    always_ff @(posedge clk) begin
        if (!rstn) begin
            reg_sel <= '0;
            cnt     <= '0;
        end else begin
            if (sel_init) begin
                reg_sel <= FIRST_SEL;
            end else if (sel_inc) begin
                reg_sel <= reg_sel + REG_IDX_W'(1);
            end
            if (cnt_load) begin
                cnt <= SETTLE_INIT;
            end else if (cnt_dec) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

`ifdef REG_DUMP_CSUM_EN
    // Running XOR of captured words, cleared at the start edge
    always_ff @(posedge clk) begin
        if (!rstn) begin
            csum <= '0;
        end else if (sel_init) begin
            csum <= '0;
        end else if (capture) begin
            csum <= csum ^ reg_data;
        end
    end
`endif

    reg_dump_outreg u_outreg (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load),
        .load_data (load_data),
        .load_idx  (load_idx),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb/tb_reg_dump_ctrl.sv - self-checking bench for reg_dump_ctrl (default and REG_DUMP_CSUM_EN builds)
module tb_reg_dump_ctrl;

`ifdef REG_DUMP_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;

    logic        start2 = 1'b0;
    logic        ready2 = 1'b0;
    logic [4:0]  reg_sel2;
    logic [31:0] reg_data2;
    logic        valid2;
    logic [31:0] data2;
    logic [4:0]  idx2;
    logic        last2;
    logic        busy2;

    always #5 clk = ~clk;

    assign reg_data  = 32'hA5A5_0000 | {27'd0, reg_sel};
    assign reg_data2 = 32'hA5A5_0000 | {27'd0, reg_sel2};

    reg_dump_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    reg_dump_ctrl #(.FIRST_REG(7), .LAST_REG(7), .SETTLE_CYC(3)) dut2 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start2),
        .reg_sel   (reg_sel2),
        .reg_data  (reg_data2),
        .out_valid (valid2),
        .out_ready (ready2),
        .out_data  (data2),
        .out_idx   (idx2),
        .out_last  (last2),
        .busy      (busy2)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        last;
        logic        is_csum;
    } exp_t;

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic        exp_busy;
        logic [4:0]  exp_sel;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vec[8];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   prev_acc = -1;
    bit   chk_gap = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        logic [31:0] x;
        logic [31:0] d;
        x = '0;
        for (int i = 0; i < 32; i++) begin
            d = 32'hA5A5_0000 | i;
            x = x ^ d;
            sb.push_back('{d, 5'(i), (i == 31) && !CSUM_ON, 1'b0});
        end
        if (CSUM_ON) sb.push_back('{x, 5'd31, 1'b1, 1'b1});
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 400) begin
            step();
            k++;
        end
        check({name, "_in_time"}, 32'(k < 400), 32'd1);
    endtask

    task automatic wait_idx(input string name, input logic [4:0] idx);
        int k;
        k = 0;
        while (!(out_valid && out_idx == idx) && k < 200) begin
            step();
            k++;
        end
        check({name, "_in_time"}, 32'(k < 200), 32'd1);
    endtask

    // Scoreboard: every accepted word is matched against the next expected one
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got idx %0d data %h, expected none", out_idx, out_data);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("word%0d_data", mon_e.idx), out_data, mon_e.data);
                check($sformatf("word%0d_idx", mon_e.idx), 32'(out_idx), 32'(mon_e.idx));
                check($sformatf("word%0d_last", mon_e.idx), 32'(out_last), 32'(mon_e.last));
                if (chk_gap && prev_acc >= 0 && !mon_e.is_csum)
                    check($sformatf("word%0d_gap", mon_e.idx), 32'(cyc - prev_acc), 32'd2);
                prev_acc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 1'b0};
        vec[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 1'b0};
        vec[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 1'b0};
        vec[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'hA5A5_0007, !CSUM_ON};
        vec[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'hA5A5_0007, !CSUM_ON};
`ifdef REG_DUMP_CSUM_EN
        vec[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'hA5A5_0007, 1'b1};
`else
        vec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 1'b0};
`endif
        vec[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 1'b0};
        vec[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0, 1'b0};

        // Reset state
        rstn = 1'b0;
        repeat (3) step();
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst2_valid", 32'(valid2), 32'd0);
        check("rst2_sel", 32'(reg_sel2), 32'd0);
        rstn = 1'b1;
        step();

        // Single-register range with long settle, cycle by cycle
        for (int i = 0; i < 8; i++) begin
            start2 = vec[i].start;
            ready2 = vec[i].ready;
            step();
            check($sformatf("vec%0d_valid", i), 32'(valid2), 32'(vec[i].exp_valid));
            check($sformatf("vec%0d_busy", i), 32'(busy2), 32'(vec[i].exp_busy));
            check($sformatf("vec%0d_sel", i), 32'(reg_sel2), 32'(vec[i].exp_sel));
            if (vec[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), data2, vec[i].exp_data);
                check($sformatf("vec%0d_idx", i), 32'(idx2), 32'd7);
                check($sformatf("vec%0d_last", i), 32'(last2), 32'(vec[i].exp_last));
            end
        end

        // Full default dump with ready held high: latency and throughput
        out_ready = 1'b1;
        push_dump();
        chk_gap = 1'b1;
        prev_acc = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_valid_after_start_edge", 32'(out_valid), 32'd0);
        check("t1_busy_after_start_edge", 32'(busy), 32'd1);
        check("t1_sel_after_start_edge", 32'(reg_sel), 32'd0);
        step();
        check("t1_valid_second_edge", 32'(out_valid), 32'd1);
        check("t1_first_idx", 32'(out_idx), 32'd0);
        wait_done("t1_done");
        check("t1_busy_cleared", 32'(busy), 32'd0);
        check("t1_valid_cleared", 32'(out_valid), 32'd0);
        chk_gap = 1'b0;
        step();

        // Backpressure at idx 3
        push_dump();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idx("t2_reach3", 5'd3);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t2_hold%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("t2_hold%0d_data", i), out_data, 32'hA5A5_0003);
            check($sformatf("t2_hold%0d_sel", i), 32'(reg_sel), 32'd3);
        end
        out_ready = 1'b1;
        step();
        check("t2_after_hs_valid", 32'(out_valid), 32'd0);
        check("t2_after_hs_sel", 32'(reg_sel), 32'd4);
        step();
        check("t2_idx4_valid", 32'(out_valid), 32'd1);
        check("t2_idx4_idx", 32'(out_idx), 32'd4);
        wait_done("t2_done");
        step();

        // Reset in the middle of a dump
        push_dump();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idx("t4_reach10", 5'd10);
        rstn = 1'b0;
        step();
        check("t4_rst_sel", 32'(reg_sel), 32'd0);
        check("t4_rst_valid", 32'(out_valid), 32'd0);
        check("t4_rst_data", out_data, 32'd0);
        check("t4_rst_idx", 32'(out_idx), 32'd0);
        check("t4_rst_last", 32'(out_last), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        rstn = 1'b1;
        step();
        push_dump();
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4_restart_sel", 32'(reg_sel), 32'd0);
        check("t4_restart_busy", 32'(busy), 32'd1);
        wait_done("t4_done");
        step();

        // Start held high: one dump per IDLE entry
        push_dump();
        push_dump();
        start = 1'b1;
        step();
        begin
            int k;
            k = 0;
            while (busy && k < 400) begin
                step();
                k++;
            end
            check("t5_first_end_in_time", 32'(k < 400), 32'd1);
        end
        check("t5_idle_gap_busy", 32'(busy), 32'd0);
        check("t5_first_dump_consumed", 32'(sb.size()), CSUM_ON ? 32'd33 : 32'd32);
        step();
        check("t5_second_busy", 32'(busy), 32'd1);
        check("t5_second_sel", 32'(reg_sel), 32'd0);
        start = 1'b0;
        wait_done("t5_done");
        repeat (5) step();
        check("t5_no_third_dump", 32'(busy), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
